// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite master fed by a valid/ready command port.
// Define AXI_LITE_CMD_MASTER_TIMEOUT_EN to build the hung-slave watchdog abort.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 256
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, RSP} state_t;

    state_t state;
    logic   busy;
    logic   wd_expired;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign busy = (state == WRITE) || (state == WRESP) || (state == READ) || (state == RRESP);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(C_TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_flag;

    assign wd_expired  = busy && (wd_cnt == CNT_LIM);
    assign rsp_timeout = timeout_flag;

    // Watchdog: restarts on every accepted command, saturates at the abort point
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (busy && !wd_expired) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expired) begin
                timeout_flag <= 1'b1;
            end else if (state == IDLE && cmd_valid && cmd_ready) begin
                timeout_flag <= 1'b0;
            end
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else if (wd_expired) begin
            // Deliberate protocol abort: drop every handshake and report SLVERR
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_resp      <= 2'b10;
            rsp_rdata     <= '0;
            rsp_valid     <= 1'b1;
            state         <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        M_AXI_AWADDR <= cmd_addr;
                        M_AXI_ARADDR <= cmd_addr;
                        M_AXI_WDATA  <= cmd_wdata;
                        M_AXI_WSTRB  <= cmd_wstrb;
                        if (cmd_write) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= READ;
                        end
                    end
                end
                WRITE: begin
                    // AW and W complete independently; a VALID already low counts as done
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                READ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RRESP;
                    end
                end
                RRESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized self-checking bench for axi_lite_cmd_master with a delay-programmable AXI4-Lite slave.
module tb_axi_lite_cmd_master;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_TIMEOUT_CYCLES(TMO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration (written by the stimulus process between transactions)
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    bit          allow_abort = 1'b0;

    // Slave state and observations
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_done, w_done, b_owed, r_owed;
    bit          p_aw, p_w, p_b, p_ar, p_r, pv_aw, pv_w, pv_ar;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, viol = 0;
    logic [AW-1:0] seen_awaddr, seen_araddr;
    logic [DW-1:0] seen_wdata;
    logic [3:0]    seen_wstrb;

    task automatic slave_arm();
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_done = 0; w_done = 0; b_owed = 0; r_owed = 0;
    endtask

    // Slave acts on falling edges; values it sees then hold until the next rising edge
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = '0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
        slave_arm();
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
                slave_arm();
            end else begin
                if (!allow_abort && ((pv_aw && !p_aw && !awvalid) || (pv_w && !p_w && !wvalid) ||
                                     (pv_ar && !p_ar && !arvalid)))
                    viol++;
                if (p_aw) begin aw_hs++; awready = 0; aw_done = 1; end
                if (p_w)  begin w_hs++;  wready = 0;  w_done = 1;  end
                if (p_b)  begin b_hs++;  bvalid = 0; end
                if (p_ar) begin ar_hs++; arready = 0; r_owed = 1; end
                if (p_r)  begin r_hs++;  rvalid = 0; end
                if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_owed = 1; end
                if (awvalid && !awready) begin
                    if (aw_wait >= aw_dly) begin awready = 1; seen_awaddr = awaddr; end
                    else aw_wait++;
                end
                if (wvalid && !wready) begin
                    if (w_wait >= w_dly) begin wready = 1; seen_wdata = wdata; seen_wstrb = wstrb; end
                    else w_wait++;
                end
                if (b_owed) begin
                    if (b_wait >= b_dly) begin bvalid = 1; bresp = cfg_bresp; b_owed = 0; end
                    else b_wait++;
                end
                if (arvalid && !arready) begin
                    if (ar_wait >= ar_dly) begin arready = 1; seen_araddr = araddr; end
                    else ar_wait++;
                end
                if (r_owed) begin
                    if (r_wait >= r_dly) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_owed = 0; end
                    else r_wait++;
                end
                p_aw = awvalid && awready;
                p_w  = wvalid && wready;
                p_b  = bvalid && bready;
                p_ar = arvalid && arready;
                p_r  = rvalid && rready;
                pv_aw = awvalid; pv_w = wvalid; pv_ar = arvalid;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin step(); n++; end
        check("cmd_accept", cmd_ready, 1'b1);
    endtask

    // One command end to end; a/w are address/data delays, b is the response delay
    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [3:0] ws, input int a, input int w, input int b,
                          input int hold, input logic [1:0] resp, input logic [DW-1:0] rd);
        int m, lim, aw0, w0, b0, ar0, r0;
        logic [6:0]    exp_tl;
        logic [DW-1:0] exp_rdata;
        if (wr) begin aw_dly = a; w_dly = w; b_dly = b; cfg_bresp = resp; end
        else begin ar_dly = a; r_dly = b; cfg_rresp = resp; cfg_rdata = rd; end
        slave_arm();
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        wait_ready();
        step();
        cmd_valid = 1'b0;
        if (wr) check("aw_w_fields", {awaddr, wdata, wstrb, awprot}, {addr, wd, ws, 3'b000});
        else    check("ar_fields", {araddr, arprot}, {addr, 3'b000});
        m   = wr ? ((a > w) ? a : w) : a;
        lim = m + b + 2;
        for (int k = 0; k <= lim; k++) begin
            if (k > 0) step();
            exp_tl = {wr && (k <= a), wr && (k <= w), wr && (k > m) && (k <= m + b + 1),
                      !wr && (k <= a), !wr && (k > a) && (k <= a + b + 1), 1'b0, k == lim};
            check("timeline", {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid}, exp_tl);
        end
        exp_rdata = wr ? '0 : rd;
        check("rsp_fields", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, resp, exp_rdata});
        for (int i = 0; i < hold; i++) begin
            step();
            check("rsp_hold", {rsp_valid, cmd_ready, awvalid | wvalid | arvalid, rsp_resp, rsp_rdata},
                  {1'b1, 1'b0, 1'b0, resp, exp_rdata});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_release", {rsp_valid, cmd_ready}, 2'b01);
        check("hs_count", {8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0), 8'(ar_hs - ar0), 8'(r_hs - r0)},
              wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
        if (wr) check("slave_saw_write", {seen_awaddr, seen_wdata, seen_wstrb}, {addr, wd, ws});
        else    check("slave_saw_read", seen_araddr, addr);
    endtask

    initial begin
        int b_before;
        repeat (3) step();
        check("reset_ctrl", {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
        check("reset_data", {rsp_rdata, rsp_resp, awaddr, wstrb, araddr, awprot, arprot}, '0);
        rst = 1'b0;
        check("ready_before_edge", cmd_ready, 1'b0);
        step();
        check("ready_after_release", cmd_ready, 1'b1);

        do_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, '0);
        do_cmd(1'b0, 4'h8, '0, 4'h0, 0, 0, 5, 0, 2'b00, 32'h12345678);
        do_cmd(1'b1, 4'hC, 32'hA5A5_0F0F, 4'h3, 3, 0, 1, 0, 2'b10, '0);
        do_cmd(1'b0, 4'h2, '0, 4'h0, 1, 0, 0, 10, 2'b11, 32'hCAFE_F00D);

        // Reset while waiting in WRESP: everything clears, no response appears
        aw_dly = 0; w_dly = 0; b_dly = 40; cfg_bresp = 2'b00;
        slave_arm();
        b_before = b_hs;
        cmd_write = 1'b1; cmd_addr = 4'h6; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        wait_ready();
        step();
        cmd_valid = 1'b0;
        step();
        check("in_wresp", {bready, awvalid, wvalid}, 3'b100);
        #2 rst = 1'b1;
        #1;
        check("async_reset_ctrl", {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
        check("async_reset_data", {rsp_rdata, awaddr, wdata}, '0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_reset", {cmd_ready, rsp_valid, 8'(b_hs - b_before)}, {1'b1, 1'b0, 8'd0});
        do_cmd(1'b0, 4'hA, '0, 4'h0, 0, 0, 2, 0, 2'b01, 32'h0BAD_BEEF);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
        // Slave never accepts AW: watchdog must abort and report SLVERR + timeout
        allow_abort = 1'b1;
        aw_dly = 100000; w_dly = 0; b_dly = 0;
        slave_arm();
        cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        wait_ready();
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k <= TMO + 1; k++) begin
            if (k > 0) step();
            check("wd_timeline", {awvalid, wvalid, bready, rsp_valid},
                  {k <= TMO, k == 0, 1'b0, k == TMO + 1});
        end
        check("wd_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wd_release", {rsp_valid, cmd_ready}, 2'b01);
        allow_abort = 1'b0;
`endif

        for (int t = 0; t < 24; t++) begin
            do_cmd(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2'($urandom), $urandom);
        end

        check("valid_stability", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

AXI4-Lite master that turns single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions. It returns each transaction's BRESP/RRESP and read data on a registered response port. The block is the initiator counterpart of the team's AXI4-Lite register slaves: it drives their S_AXI ports from control logic and from the SPI bridge datapath. It handles one outstanding transaction at a time.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4: AXI address width.
- C_M_AXI_DATA_WIDTH, 32: AXI data width; must be 32 or 64.
- C_TIMEOUT_CYCLES, 256: watchdog limit in cycles. Used only when the watchdog is compiled in.

Ports:
- M_AXI_ACLK  in  1  clock; all logic is on the rising edge.
- M_AXI_ARESET  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- rsp_timeout  out  1  transaction was aborted by the watchdog.
- M_AXI_AWADDR/AWPROT/AWVALID, AWREADY  out/out/out, in  ADDR/3/1, 1  write address channel.
- M_AXI_WDATA/WSTRB/WVALID, WREADY  out/out/out, in  DATA/DATA/8/1, 1  write data channel.
- M_AXI_BRESP, BVALID, BREADY  in, in, out  2, 1, 1  write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID, ARREADY  out/out/out, in  ADDR/3/1, 1  read address channel.
- M_AXI_RDATA, RRESP, RVALID, RREADY  in, in, in, out  DATA, 2, 1, 1  read data channel.

## Operation
- States: IDLE, WRITE, WRESP, READ, RRESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/wdata/wstrb into the AXI output registers.
  - Go to WRITE if cmd_write=1, otherwise READ.
- WRITE:
  - AWVALID and WVALID are both high, issued together.
  - Each VALID drops in the cycle after its own handshake. The two handshakes may occur in the same cycle or in either order.
  - When both are done, go to WRESP.
- WRESP:
  - BREADY=1.
  - On BVALID, capture BRESP into rsp_resp, clear rsp_rdata to 0, and go to RSP.
- READ:
  - ARVALID=1.
  - On ARREADY, go to RRESP.
- RRESP:
  - RREADY=1.
  - On RVALID, capture RDATA and RRESP, and go to RSP.
- RSP:
  - rsp_valid=1, with response fields held stable.
  - On rsp_ready, go to IDLE.
- AWPROT and ARPROT are constant 3'b000. Addresses pass through unmodified; no alignment check.
- Once asserted, VALID signals stay high until their handshake. The only exception is a watchdog abort.
- A slave error (resp 2'b10 or 2'b11) is reported, not retried.

## Timing
- Reset values:
  - All outputs 0: cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, and every AXI VALID/READY/addr/data/strb/prot.
  - State is IDLE.
  - cmd_ready rises in the first clock edge after reset release.
- Reset asserted mid-transaction forces reset values immediately (asynchronous). The transaction is abandoned and no response is produced.
- Command accepted at edge N: AWVALID/WVALID/ARVALID are high from N+1.
- Write with a zero-wait slave: AW and W handshake at N+1, BVALID at N+2, rsp_valid at N+3.
- Read with a zero-wait slave: AR handshake at N+1, RVALID at N+2, rsp_valid at N+3.
- BREADY and RREADY are registered. They are high from state entry until the handshake edge.
- In the same RSP cycle, rsp_valid&rsp_ready returns the block to IDLE, with cmd_ready=1 on the next cycle. Back-to-back throughput is therefore one transaction per 4 cycles minimum.
- cmd_ready is low in every state except IDLE. Commands are never dropped; the upstream holds cmd_valid.

## Configuration
- Macro AXI_LITE_CMD_MASTER_TIMEOUT_EN.
- When the macro is defined:
  - A cycle counter of width clog2(C_TIMEOUT_CYCLES+1) clears on leaving IDLE.
  - It counts every cycle in WRITE, WRESP, READ and RRESP.
  - When it reaches C_TIMEOUT_CYCLES, all AXI VALID/READY outputs drop on the next edge and the state goes to RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
  - This deliberate protocol abort is the recovery path for a hung slave.
- When the macro is undefined:
  - No counter is built and rsp_timeout is tied to 0.
  - The block waits indefinitely for the slave.

## Test plan
- Write 0xDEADBEEF, wstrb 4'hF, to addr 0x4 with a zero-wait slave -> AWADDR=0x4 and WDATA=0xDEADBEEF at N+1; rsp_valid at N+3 with rsp_resp=0 and rsp_rdata=0.
- Read addr 0x8 where the slave returns 0x12345678, with RVALID delayed 5 cycles -> rsp_rdata=0x12345678 and rsp_resp=0; RREADY is held high through the wait.
- Write where WREADY precedes AWREADY by 3 cycles -> WVALID drops after its handshake, AWVALID stays high until its own; exactly one B handshake occurs.
- Hold rsp_ready=0 for 10 cycles after a read -> rsp_valid and rsp_rdata stay stable; cmd_ready=0 and no new AXI activity occurs.
- Assert M_AXI_ARESET while in WRESP -> all outputs are 0 asynchronously; after release, a new read completes normally.
- With the macro defined and C_TIMEOUT_CYCLES=16, a slave that never asserts AWREADY -> rsp_valid occurs with rsp_resp=2'b10 and rsp_timeout=1 about 17 cycles after accept, and AWVALID is low.
